bus_monitor: RTL and testbench

Synthesizable successor to the simulation-only bus watcher around `core`/`memory`. It snoops the shared memory bus, raises a sticky halt flag when the core touches a programmable halt address, and stops with a timeout flag after a programmable cycle budget. MMIO writes into a programmable address window are captured into a log FIFO, which a host, UART bridge or testbench drains through a valid/ready port. It sits beside `memory` on the same bus and never drives the bus.

---
 rtl/bus_monitor_pkg.sv | 15 +
 rtl/bus_monitor_if.sv | 26 ++
 rtl/bus_monitor_sync_fifo.sv | 51 +++++
 rtl/bus_monitor.sv | 102 ++++++++++
 tb/tb_bus_monitor.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_monitor_pkg.sv
// Shared types for the bus monitor: run-state encoding and log entry sizing.
package bus_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  // One log entry is {address, data, byte enables}.
  function automatic int log_entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/bus_monitor_if.sv
// Snooped memory bus plus the log drain port; master = core/consumer side, slave = monitor.
interface bus_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   data_out;
  logic [DATA_W/8-1:0] byte_enable;
  logic                we;

  logic                log_valid;
  logic                log_ready;
  logic [ADDR_W-1:0]   log_addr;
  logic [DATA_W-1:0]   log_data;
  logic [DATA_W/8-1:0] log_be;

  modport master (
    output address, data_out, byte_enable, we, log_ready,
    input  log_valid, log_addr, log_data, log_be
  );

  modport slave (
    input  address, data_out, byte_enable, we, log_ready,
    output log_valid, log_addr, log_data, log_be
  );
endinterface

// File: rtl/bus_monitor_sync_fifo.sv
// Synchronous FIFO, registered storage, head visible 1 cycle after push.
// Push is accepted when not full or when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             full_o,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_dat_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  assign pop_vld_o = (wr_q != rd_q);
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_dat_o = mem_q[rd_q[AW-1:0]];

  assign pop  = pop_vld_o && pop_rdy_i;
  assign push = push_vld_i && (!full_o || pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/bus_monitor.sv
// Bus snooper: sticky halt/timeout flags, RUN cycle counter, MMIO write log with drop counter.
// All outputs registered; flags update the edge after sampling; log drained via valid/ready.
module bus_monitor
  import bus_monitor_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR      = 'h0000_0FFC,
  parameter logic [ADDR_W-1:0] MMIO_MASK      = 'h0000_0800,
  parameter logic [ADDR_W-1:0] MMIO_MATCH     = 'h0000_0800,
  parameter int                LOG_DEPTH      = 8,
  parameter int unsigned       TIMEOUT_CYCLES = 2000,
  parameter int                CNT_W          = 32
) (
  input  logic             clk,
  input  logic             resetn,
  bus_monitor_if.slave     bus,
  output logic             halted,
  output logic             timeout,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] drop_count
);
  localparam int EW = log_entry_w(ADDR_W, DATA_W);

  state_e           state_q;
  logic             halted_q, timeout_q, running_q;
  logic [CNT_W-1:0] cycle_q, cycle_d, drop_q, drop_d;
  logic             hit_halt, hit_timeout, in_window, capture, drop;
  logic             fifo_full, fifo_vld, pop;
  logic [EW-1:0]    fifo_dat;

  assign hit_halt    = (bus.address == HALT_ADDR);
  assign hit_timeout = (TIMEOUT_CYCLES != 0) && (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign in_window   = ((bus.address & MMIO_MASK) == MMIO_MATCH);
  assign capture     = (state_q == ST_RUN) && bus.we && in_window;
  assign pop         = fifo_vld && bus.log_ready;
  assign drop        = capture && fifo_full && !pop;

  always_comb begin
    cycle_d = cycle_q;
    if (state_q == ST_RUN && !(&cycle_q)) cycle_d = cycle_q + 1'b1;
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && !(&drop_q)) drop_d = drop_q + 1'b1;
  end

  // Halt takes priority when both conditions land on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      running_q <= 1'b1;
      cycle_q   <= '0;
    end else begin
      cycle_q <= cycle_d;
      if (state_q == ST_RUN) begin
        if (hit_halt) begin
          state_q   <= ST_HALT;
          halted_q  <= 1'b1;
          running_q <= 1'b0;
        end else if (hit_timeout) begin
          state_q   <= ST_TIMEOUT;
          timeout_q <= 1'b1;
          running_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) drop_q <= '0;
    else         drop_q <= drop_d;
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_vld_i (capture),
    .push_dat_i ({bus.address, bus.data_out, bus.byte_enable}),
    .full_o     (fifo_full),
    .pop_vld_o  (fifo_vld),
    .pop_rdy_i  (bus.log_ready),
    .pop_dat_o  (fifo_dat)
  );

  assign bus.log_valid = fifo_vld;
  assign {bus.log_addr, bus.log_data, bus.log_be} = fifo_dat;

  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign running     = running_q;
  assign cycle_count = cycle_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_bus_monitor.sv
// Directed + randomized bench for bus_monitor against a queue-based reference model.
module tb_bus_monitor;
  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 8;
  localparam longint      TIMEOUT  = 2000;
  localparam logic [31:0] HALT_A   = 32'h0000_0FFC;
  localparam logic [31:0] MASK     = 32'h0000_0800;
  localparam logic [31:0] MATCH    = 32'h0000_0800;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic        clk;
  logic        resetn;
  logic        halted, timeout, running;
  logic [31:0] cycle_count, drop_count;

  bus_monitor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  bus_monitor dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bif),
    .halted      (halted),
    .timeout     (timeout),
    .running     (running),
    .cycle_count (cycle_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit              m_halt, m_to;
  longint unsigned m_cnt, m_drop;
  ent_t            m_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit   run;
    bit   budget_done;
    ent_t e;
    if (!resetn) begin
      m_halt = 0; m_to = 0; m_cnt = 0; m_drop = 0;
      m_q.delete();
    end else begin
      run = !m_halt && !m_to;
      if (m_q.size() > 0 && bif.log_ready) void'(m_q.pop_front());
      if (run && bif.we && ((bif.address & MASK) == MATCH)) begin
        e.addr = bif.address; e.data = bif.data_out; e.be = bif.byte_enable;
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else if (m_drop != 64'hFFFF_FFFF) m_drop++;
      end
      if (run) begin
        budget_done = (TIMEOUT != 0) && (m_cnt + 1 == TIMEOUT);
        if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
        if (bif.address == HALT_A) m_halt = 1;
        else if (budget_done)      m_to = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("halted",      {63'd0, halted},  {63'd0, m_halt});
    check("timeout",     {63'd0, timeout}, {63'd0, m_to});
    check("running",     {63'd0, running}, {63'd0, !m_halt && !m_to});
    check("cycle_count", {32'd0, cycle_count}, m_cnt);
    check("drop_count",  {32'd0, drop_count},  m_drop);
    check("log_valid",   {63'd0, bif.log_valid}, {63'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      check("log_addr", {32'd0, bif.log_addr}, {32'd0, m_q[0].addr});
      check("log_data", {32'd0, bif.log_data}, {32'd0, m_q[0].data});
      check("log_be",   {60'd0, bif.log_be},   {60'd0, m_q[0].be});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic w, input logic rdy);
    bif.address = a; bif.data_out = d; bif.byte_enable = be; bif.we = w; bif.log_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(32'h0, 32'h0, 4'h0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle(1'b0);
    step();
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    resetn = 1'b0;
    idle(1'b0);

    // Reset state
    step();
    check("rst_running", {63'd0, running}, 64'd1);
    check("rst_cycle",   {32'd0, cycle_count}, 64'd0);
    resetn = 1'b1;

    // Single MMIO write, consumer ready
    drive(32'h800, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
    step();
    check("cap_addr", {32'd0, bif.log_addr}, 64'h800);
    check("cap_data", {32'd0, bif.log_data}, 64'h1234_5678);
    idle(1'b1);
    step();
    check("cap_gone", {63'd0, bif.log_valid}, 64'd0);
    check("cap_drop", {32'd0, drop_count},    64'd0);

    // Randomized traffic, never hitting the halt address
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       a = 32'h800 + ($urandom_range(0, 511) << 2);
        1:       a = $urandom & 32'h0000_07FC;
        2:       a = $urandom;
        default: a = 32'h1800 | ($urandom & 32'h3FC);
      endcase
      if (a == HALT_A) a = 32'h800;
      drive(a, $urandom, 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1);
      step();
    end

    // Halt on read of the halt address with cycle_count at 37
    do_reset();
    for (int i = 0; i < 37; i++) step();
    drive(HALT_A, 32'h0, 4'h0, 1'b0, 1'b1);
    step();
    check("halt_flag",  {63'd0, halted},  64'd1);
    check("halt_run",   {63'd0, running}, 64'd0);
    check("halt_cycle", {32'd0, cycle_count}, 64'd38);
    drive(32'h804, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    step();
    step();
    check("halt_nolog",  {63'd0, bif.log_valid}, 64'd0);
    check("halt_frozen", {32'd0, cycle_count},   64'd38);

    // Overflow: 10 writes with consumer stalled
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(32'h800 + 32'(i * 4), 32'(i), 4'h3, 1'b1, 1'b0);
      step();
    end
    check("ovf_drop", {32'd0, drop_count}, 64'd2);
    idle(1'b1);
    for (int k = 0; k < 8; k++) begin
      check("drain_addr", {32'd0, bif.log_addr}, 64'h800 + 64'(k * 4));
      step();
    end
    check("drain_empty", {63'd0, bif.log_valid}, 64'd0);

    // Full FIFO with capture coinciding with pop
    for (int i = 0; i < 8; i++) begin
      drive(32'h900 + 32'(i * 4), 32'(i), 4'h1, 1'b1, 1'b0);
      step();
    end
    drive(32'h9F0, 32'hCAFE, 4'h8, 1'b1, 1'b1);
    step();
    check("fullpop_drop", {32'd0, drop_count}, 64'd2);
    idle(1'b1);
    for (int i = 0; i < 9; i++) step();

    // Timeout after exactly 2000 RUN edges
    do_reset();
    for (int i = 0; i < 1999; i++) step();
    check("to_before", {63'd0, timeout}, 64'd0);
    step();
    check("to_flag",  {63'd0, timeout}, 64'd1);
    check("to_cycle", {32'd0, cycle_count}, 64'd2000);
    check("to_halt",  {63'd0, halted}, 64'd0);
    drive(HALT_A, 32'h0, 4'h0, 1'b0, 1'b1);
    step();
    check("to_sticky", {63'd0, halted}, 64'd0);

    // Halt and timeout on the same edge: halt wins
    do_reset();
    for (int i = 0; i < 1999; i++) step();
    drive(HALT_A, 32'h0, 4'h0, 1'b0, 1'b1);
    step();
    check("both_halt", {63'd0, halted},  64'd1);
    check("both_to",   {63'd0, timeout}, 64'd0);

    // Reset while halted with entries queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(32'hA00 + 32'(i * 4), 32'(i + 5), 4'hF, 1'b1, 1'b0);
      step();
    end
    drive(HALT_A, 32'h0, 4'h0, 1'b0, 1'b0);
    step();
    check("pre_rst_halt", {63'd0, halted}, 64'd1);
    do_reset();
    check("rst_valid", {63'd0, bif.log_valid}, 64'd0);
    check("rst_halt",  {63'd0, halted},        64'd0);
    idle(1'b1);
    step();
    check("rst_empty", {63'd0, bif.log_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
